// File: rtl/huffman_decoder_if.sv
// Bundle of the decoder's table-load, bit-stream and symbol-output signals.
// The master modport drives the table and bits; the slave modport belongs to the decoder.
interface huffman_decoder_if #(
    parameter int CW = 8
);
    logic          code_valid;
    logic [CW-1:0] HC1, HC2, HC3, HC4, HC5, HC6;
    logic [CW-1:0] M1, M2, M3, M4, M5, M6;
    logic          bit_valid;
    logic          bit_in;
    logic          sym_valid;
    logic [2:0]    sym_out;
    logic          err;
    logic          busy;
    logic [7:0]    dec_cnt;

    modport master (
        output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
        output M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        input  sym_valid, sym_out, err, busy, dec_cnt
    );

    modport slave (
        input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
        input  M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        output sym_valid, sym_out, err, busy, dec_cnt
    );
endinterface

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: loads a 6-entry codeword/mask table, then shifts in one
// bit per qualified cycle and emits the matching symbol index 1..6.
module huffman_decoder #(
    parameter int CW   = 8,
    parameter int NSYM = 6
) (
    input  logic              clk,
    input  logic              reset,
    huffman_decoder_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hc_q [NSYM];
    logic [CW-1:0] hc_d [NSYM];
    logic [CW-1:0] m_q  [NSYM];
    logic [CW-1:0] m_d  [NSYM];
    logic [CW-1:0] tbl_hc [NSYM];
    logic [CW-1:0] tbl_m  [NSYM];
    logic [CW-1:0] acc_q, acc_d, acc_n, lm;
    logic [3:0]    len_q, len_d, len_n;
    logic          sym_valid_q, sym_valid_d;
    logic [2:0]    sym_out_q, sym_out_d;
    logic          err_q, err_d;
    logic [7:0]    dec_cnt_q, dec_cnt_d;
    logic          hit;
    logic [2:0]    hit_sym;

    always_comb begin
        tbl_hc[0] = bus.HC1; tbl_hc[1] = bus.HC2; tbl_hc[2] = bus.HC3;
        tbl_hc[3] = bus.HC4; tbl_hc[4] = bus.HC5; tbl_hc[5] = bus.HC6;
        tbl_m[0]  = bus.M1;  tbl_m[1]  = bus.M2;  tbl_m[2]  = bus.M3;
        tbl_m[3]  = bus.M4;  tbl_m[4]  = bus.M5;  tbl_m[5]  = bus.M6;
    end

    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        m_d         = m_q;
        acc_d       = acc_q;
        len_d       = len_q;
        sym_valid_d = 1'b0;
        sym_out_d   = sym_out_q;
        err_d       = 1'b0;
        dec_cnt_d   = dec_cnt_q;

        acc_n = CW'({acc_q, bus.bit_in});
        len_n = len_q + 4'd1;
        // Mask is formed one bit wider so a full-length code yields all ones.
        lm    = CW'(({{CW{1'b0}}, 1'b1} << len_n) - 1'b1);

        hit     = 1'b0;
        hit_sym = '0;
        for (int unsigned k = 0; k < NSYM; k++) begin
            if (!hit && m_q[k] != '0 && m_q[k] == lm && (acc_n & m_q[k]) == hc_q[k]) begin
                hit     = 1'b1;
                hit_sym = 3'(k + 1);
            end
        end

        if (bus.code_valid) begin
            state_d   = RUN;
            hc_d      = tbl_hc;
            m_d       = tbl_m;
            acc_d     = '0;
            len_d     = '0;
            dec_cnt_d = '0;
        end else if (state_q == RUN && bus.bit_valid) begin
            if (hit) begin
                sym_valid_d = 1'b1;
                sym_out_d   = hit_sym;
                dec_cnt_d   = dec_cnt_q + 8'd1;
                acc_d       = '0;
                len_d       = '0;
            end else if (len_n == 4'(CW)) begin
                err_d = 1'b1;
                acc_d = '0;
                len_d = '0;
            end else begin
                acc_d = acc_n;
                len_d = len_n;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int unsigned k = 0; k < NSYM; k++) begin
                hc_q[k] <= '0;
                m_q[k]  <= '0;
            end
            acc_q       <= '0;
            len_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_out_q   <= '0;
            err_q       <= 1'b0;
            dec_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            sym_valid_q <= sym_valid_d;
            sym_out_q   <= sym_out_d;
            err_q       <= err_d;
            dec_cnt_q   <= dec_cnt_d;
        end
    end

    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_out   = sym_out_q;
    assign bus.err       = err_q;
    assign bus.busy      = (len_q != '0);
    assign bus.dec_cnt   = dec_cnt_q;
endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed table scenarios plus random symbol streams,
// each cycle compared against a bit-string reference model of the code table.
module tb_huffman_decoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    huffman_decoder_if #(.CW(8)) bus ();
    huffman_decoder #(.CW(8), .NSYM(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_err = 0;
    int n_chk = 0;

    int cur_hc [6];
    int cur_m  [6];

    // Reference model state: the pending bits as a number plus its bit count.
    bit m_run;
    int t_hc [6];
    int t_m  [6];
    int m_val, m_len, m_cnt, m_so;
    bit m_sv, m_err;

    function automatic int code_len(input int m);
        int n = 0;
        for (int i = 0; i < 8; i++) if ((m >> i) & 1) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sym_valid", int'(bus.sym_valid), int'(m_sv));
        chk("sym_out",   int'(bus.sym_out),   m_so);
        chk("err",       int'(bus.err),       int'(m_err));
        chk("busy",      int'(bus.busy),      (m_len != 0) ? 1 : 0);
        chk("dec_cnt",   int'(bus.dec_cnt),   m_cnt);
    endtask

    task automatic model_reset();
        m_run = 0; m_val = 0; m_len = 0; m_cnt = 0; m_so = 0; m_sv = 0; m_err = 0;
        for (int k = 0; k < 6; k++) begin t_hc[k] = 0; t_m[k] = 0; end
    endtask

    task automatic model_step(input bit cv, input bit bv, input bit b);
        int found;
        m_sv = 0; m_err = 0;
        if (cv) begin
            t_hc = cur_hc; t_m = cur_m;
            m_run = 1; m_val = 0; m_len = 0; m_cnt = 0;
        end else if (m_run && bv) begin
            m_val = m_val * 2 + int'(b);
            m_len++;
            found = 0;
            for (int k = 0; k < 6; k++)
                if (found == 0 && t_m[k] != 0 && code_len(t_m[k]) == m_len && t_hc[k] == m_val)
                    found = k + 1;
            if (found != 0) begin
                m_sv = 1; m_so = found; m_cnt = (m_cnt + 1) % 256;
                m_val = 0; m_len = 0;
            end else if (m_len == 8) begin
                m_err = 1; m_val = 0; m_len = 0;
            end
        end
    endtask

    task automatic cycle(input bit cv, input bit bv, input bit b);
        bus.code_valid = cv; bus.bit_valid = bv; bus.bit_in = b;
        bus.HC1 = 8'(cur_hc[0]); bus.HC2 = 8'(cur_hc[1]); bus.HC3 = 8'(cur_hc[2]);
        bus.HC4 = 8'(cur_hc[3]); bus.HC5 = 8'(cur_hc[4]); bus.HC6 = 8'(cur_hc[5]);
        bus.M1 = 8'(cur_m[0]); bus.M2 = 8'(cur_m[1]); bus.M3 = 8'(cur_m[2]);
        bus.M4 = 8'(cur_m[3]); bus.M5 = 8'(cur_m[4]); bus.M6 = 8'(cur_m[5]);
        @(posedge clk);
        #1;
        model_step(cv, bv, b);
        check_all();
        bus.code_valid = 1'b0; bus.bit_valid = 1'b0;
    endtask

    task automatic send_bit(input bit b, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'($urandom));
        cycle(1'b0, 1'b1, b);
    endtask

    task automatic send_sym(input int k, input bit gaps);
        int len = code_len(cur_m[k-1]);
        for (int i = len - 1; i >= 0; i--) send_bit(1'((cur_hc[k-1] >> i) & 1), gaps);
    endtask

    task automatic set_t1();
        cur_hc = '{1, 1, 1, 1, 1, 0};
        cur_m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    endtask

    initial begin
        bus.code_valid = 0; bus.bit_valid = 0; bus.bit_in = 0;
        set_t1();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Bits before any table load are ignored.
        cycle(1'b0, 1'b1, 1'b1);

        // Single 1-bit code, then the full alphabet with gaps.
        cycle(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 6; k++) send_sym(k, 1'b1);

        // Back-to-back 1-bit codes, long enough to wrap dec_cnt.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (260) send_bit(1'b1, 1'b0);

        // Recapture mid-codeword discards the partial code.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) send_bit(1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0);

        // Random symbol stream with gaps and occasional recapture carrying a dropped bit.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) cycle(1'b1, 1'b1, 1'($urandom));
            else send_sym($urandom_range(1, 6), 1'($urandom));
        end

        // Sparse table: only "1" decodes, eight zeros overflow into err.
        cur_hc = '{1, 0, 0, 0, 0, 0};
        cur_m  = '{8'h01, 0, 0, 0, 0, 0};
        cycle(1'b1, 1'b0, 1'b0);
        repeat (8) send_bit(1'b0, 1'b0);
        repeat (60) send_bit(1'($urandom_range(0, 9) == 0), 1'($urandom));

        // Reset mid-codeword returns to idle; bits afterwards are ignored.
        set_t1();
        cycle(1'b1, 1'b0, 1'b0);
        send_sym(3, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
